// File: rtl/acc_drain_arbiter.sv
// acc_drain_arbiter: drains the PE accumulators into the output memory
// write port after a layer pass. PEs that request a drain are served in
// round-robin order. Each accumulator is read in one cycle and written in
// the next, and completion is reported with a done pulse.
// Optional build macro: ACC_RELU_EN. When defined, negative results are
// written as zero.
module acc_drain_arbiter #(
  parameter int NUM_PE     = 8,
  parameter int ACC_PER_PE = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             wr_base,
  input  logic [NUM_PE-1:0]             drain_req,
  output logic [NUM_PE-1:0]             drain_ack,
  output logic [$clog2(NUM_PE)-1:0]     acc_pe_sel,
  output logic [$clog2(ACC_PER_PE)-1:0] acc_idx,
  input  logic [DATA_W-1:0]             acc_data,
  output logic                          wr_valid,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int PE_W  = $clog2(NUM_PE);
  localparam int IDX_W = $clog2(ACC_PER_PE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ACC_PER_PE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_READ, S_WRITE, S_ACK, S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [NUM_PE-1:0]         served;
  logic [NUM_PE-1:0]         cand;
  logic [PE_W-1:0]           rr_ptr;
  logic [PE_W-1:0]           gnt_pe;
  logic                      gnt_found;
  logic [ADDR_W-1:0]         base_q;
  logic signed [DATA_W-1:0]  acc_p1;

`ifdef ACC_RELU_EN
  // A negative two's complement value is clamped to zero.
  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

  assign wr_data = relu(acc_p1);
`else
  assign wr_data = acc_p1;
`endif

  // The sizes are powers of two, so {pe, idx} equals pe*ACC_PER_PE+idx.
  // The sum wraps modulo 2^ADDR_W.
  assign wr_addr = base_q + ADDR_W'({acc_pe_sel, acc_idx});

  // Round-robin pick: the first pending, unserved PE at or after rr_ptr.
  // The scan runs high to low, so the lowest offset wins.
  always_comb begin
    logic [PE_W-1:0] pos;
    cand      = drain_req & ~served;
    gnt_found = 1'b0;
    gnt_pe    = '0;
    pos       = '0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      pos = rr_ptr + PE_W'(i);
      if (cand[pos]) begin
        gnt_found = 1'b1;
        gnt_pe    = pos;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded control outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    wr_valid  = 1'b0;
    drain_ack = '0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ARB;
      S_ARB: begin
        if (gnt_found)     state_nxt = S_READ;
        else if (&served)  state_nxt = S_DONE;
      end
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: begin
        wr_valid = 1'b1;
        if (wr_ready) state_nxt = (acc_idx == IDX_LAST) ? S_ACK : S_READ;
      end
      S_ACK: begin
        drain_ack = NUM_PE'(1) << acc_pe_sel;
        state_nxt = S_ARB;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Layer context, grant bookkeeping and the accumulator capture register.
  // Everything is cleared by reset so that every output reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      served     <= '0;
      rr_ptr     <= '0;
      acc_pe_sel <= '0;
      acc_idx    <= '0;
      acc_p1     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= wr_base;
            served <= '0;
          end
        end
        S_ARB: begin
          if (gnt_found) begin
            acc_pe_sel <= gnt_pe;
            acc_idx    <= '0;
          end
        end
        // p1: the selected accumulator is captured for the write cycle.
        S_READ:  acc_p1 <= acc_data;
        S_WRITE: begin
          if (wr_ready && (acc_idx != IDX_LAST)) acc_idx <= acc_idx + IDX_W'(1);
        end
        S_ACK: begin
          served[acc_pe_sel] <= 1'b1;
          rr_ptr             <= acc_pe_sel + PE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_drain_arbiter.sv
// Directed testbench for acc_drain_arbiter.
// Drives acc_data from a PE-array stand-in: pe*16+idx, or a fixed
// negative/positive pair for the ReLU step.
module tb_acc_drain_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  wr_base;
  logic [7:0]  drain_req;
  logic [7:0]  drain_ack;
  logic [2:0]  acc_pe_sel;
  logic [1:0]  acc_idx;
  logic [15:0] acc_data;
  logic        wr_valid;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        ovr_en;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int wcnt   = 0;
  int acnt   = 0;
  int dcnt   = 0;
  int done_cyc = 0;
  logic [9:0]  wa [512];
  logic [15:0] wd [512];
  logic [7:0]  ar [64];

  acc_drain_arbiter #(.NUM_PE(8), .ACC_PER_PE(4), .DATA_W(16), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_base(wr_base),
    .drain_req(drain_req), .drain_ack(drain_ack), .acc_pe_sel(acc_pe_sel),
    .acc_idx(acc_idx), .acc_data(acc_data), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    acc_data = 16'(acc_pe_sel) * 16'd16 + 16'(acc_idx);
    if (ovr_en) acc_data = acc_idx[0] ? 16'h0010 : 16'hFFF0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Log write handshakes, ack pulses and done pulses.
  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      if (wcnt < 512) begin
        wa[wcnt] <= wr_addr;
        wd[wcnt] <= wr_data;
      end
      wcnt <= wcnt + 1;
    end
    if (drain_ack != 8'h00) begin
      if (acnt < 64) ar[acnt] <= drain_ack;
      acnt <= acnt + 1;
    end
    if (done) begin
      dcnt     <= dcnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [9:0] base, output int s);
    wr_base = base;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    wr_base = 10'h2AA;
    s       = cyc;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k = 0;
    while (dcnt == d0 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(dcnt != d0), 32'd1);
  endtask

  initial begin
    int s, w0, a0, d0, k;
    logic [7:0] ord [8];
    rst = 1'b1; start = 1'b0; wr_base = '0; drain_req = '0; wr_ready = 1'b1; ovr_en = 1'b0;
    tick(3);

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_ack", 32'(drain_ack), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_sel", 32'({acc_pe_sel, acc_idx}), 32'd0);
    rst = 1'b0;
    tick(2);

    // Full layer at 0x100, all requests, no stalls
    drain_req = 8'hFF;
    w0 = wcnt; a0 = acnt; d0 = dcnt;
    pulse_start(10'h100, s);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(d0, "t1_done_seen");
    chk("t1_latency", 32'(done_cyc - s + 1), 32'd82);
    chk("t1_wcount", 32'(wcnt - w0), 32'd32);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t1_addr%0d", i), 32'(wa[w0+i]), 32'h100 + 32'(i));
      chk($sformatf("t1_data%0d", i), 32'(wd[w0+i]), 32'((i / 4) * 16 + (i % 4)));
    end
    for (int i = 0; i < 8; i++) chk($sformatf("t1_ack%0d", i), 32'(ar[a0+i]), 32'(8'h01 << i));
    tick(1);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_done_once", 32'(dcnt - d0), 32'd1);

    // Wrap at 0x3FE, stall on second write, start pulsed mid-drain
    w0 = wcnt; d0 = dcnt;
    pulse_start(10'h3FE, s);
    tick(4);
    wr_ready = 1'b0;
    @(negedge clk);
    chk("t4_stall_valid", 32'(wr_valid), 32'd1);
    chk("t4_stall_addr_a", 32'(wr_addr), 32'h3FF);
    chk("t4_stall_data_a", 32'(wr_data), 32'h0001);
    tick(1);
    start = 1'b1; wr_base = 10'h155;
    @(negedge clk);
    chk("t4_stall_addr_b", 32'(wr_addr), 32'h3FF);
    chk("t4_stall_data_b", 32'(wr_data), 32'h0001);
    chk("t4_stall_idx", 32'(acc_idx), 32'd1);
    tick(1);
    start = 1'b0; wr_ready = 1'b1;
    wait_done(d0, "t4_done_seen");
    chk("t4_latency", 32'(done_cyc - s + 1), 32'd84);
    chk("t4_wcount", 32'(wcnt - w0), 32'd32);
    chk("t4_addr0", 32'(wa[w0]), 32'h3FE);
    chk("t4_addr1", 32'(wa[w0+1]), 32'h3FF);
    chk("t4_addr2", 32'(wa[w0+2]), 32'h000);
    chk("t4_addr31", 32'(wa[w0+31]), 32'h01D);
    chk("t4_data1", 32'(wd[w0+1]), 32'h0001);
    chk("t4_data2", 32'(wd[w0+2]), 32'h0002);
    tick(2);
    chk("t4_done_once", 32'(dcnt - d0), 32'd1);

    // Partial requests: PE2 then PE5, PE2 drops its request after the grant
    drain_req = 8'b0010_0100;
    w0 = wcnt; a0 = acnt; d0 = dcnt;
    pulse_start(10'h000, s);
    tick(3);
    drain_req = 8'b0010_0000;
    tick(37);
    chk("t2_acks_partial", 32'(acnt - a0), 32'd2);
    chk("t2_ack_pe2", 32'(ar[a0]), 32'h04);
    chk("t2_ack_pe5", 32'(ar[a0+1]), 32'h20);
    chk("t2_hold_busy", 32'(busy), 32'd1);
    chk("t2_hold_no_done", 32'(dcnt - d0), 32'd0);
    chk("t2_hold_no_write", 32'(wr_valid), 32'd0);
    chk("t2_wcount_partial", 32'(wcnt - w0), 32'd8);
    chk("t2_addr_pe2", 32'(wa[w0]), 32'h008);
    chk("t2_data_pe2", 32'(wd[w0]), 32'h0020);
    chk("t2_addr_pe5", 32'(wa[w0+4]), 32'h014);
    drain_req = 8'hFF;
    wait_done(d0, "t2_done_seen");
    chk("t2_acks_total", 32'(acnt - a0), 32'd8);
    ord = '{8'h04, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h08, 8'h10};
    for (int i = 0; i < 8; i++) chk($sformatf("t2_order%0d", i), 32'(ar[a0+i]), 32'(ord[i]));
    chk("t2_wcount", 32'(wcnt - w0), 32'd32);
    tick(1);

    // Back-to-back layer: round-robin resumes at PE5
    w0 = wcnt; a0 = acnt; d0 = dcnt;
    pulse_start(10'h040, s);
    wait_done(d0, "t3_done_seen");
    chk("t3_latency", 32'(done_cyc - s + 1), 32'd82);
    ord = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    for (int i = 0; i < 8; i++) chk($sformatf("t3_order%0d", i), 32'(ar[a0+i]), 32'(ord[i]));
    chk("t3_addr0", 32'(wa[w0]), 32'h054);
    chk("t3_data0", 32'(wd[w0]), 32'h0050);
    tick(1);

    // Negative and positive accumulator values
    ovr_en = 1'b1;
    w0 = wcnt; d0 = dcnt;
    pulse_start(10'h000, s);
    wait_done(d0, "t5_done_seen");
`ifdef ACC_RELU_EN
    chk("t5_neg", 32'(wd[w0]), 32'h0000);
`else
    chk("t5_neg", 32'(wd[w0]), 32'hFFF0);
`endif
    chk("t5_pos", 32'(wd[w0+1]), 32'h0010);
    ovr_en = 1'b0;
    tick(1);

    // Asynchronous reset in the middle of a write
    pulse_start(10'h000, s);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!wr_valid && k < 20);
    chk("t6_reached_write", 32'(wr_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid_cleared", 32'(wr_valid), 32'd0);
    chk("t6_busy_cleared", 32'(busy), 32'd0);
    chk("t6_ack_cleared", 32'(drain_ack), 32'd0);
    chk("t6_data_cleared", 32'(wr_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    w0 = wcnt;
    tick(5);
    chk("t6_idle_after", 32'(busy), 32'd0);
    chk("t6_no_writes", 32'(wcnt - w0), 32'd0);

    // Reset cleared the round-robin pointer, so the next layer starts at PE0
    a0 = acnt; d0 = dcnt;
    pulse_start(10'h000, s);
    wait_done(d0, "t7_done_seen");
    chk("t7_latency", 32'(done_cyc - s + 1), 32'd82);
    chk("t7_first_ack", 32'(ar[a0]), 32'h01);
    chk("t7_acks", 32'(acnt - a0), 32'd8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
